fpu_seq: RTL and testbench

Operand/result sequencer sitting directly upstream of the AWP floating-point unit. On an FP/extended-arithmetic instruction it streams register and memory operands word-by-word into AWP, launches the operation, waits for completion, writes the result words back to r1..r3 and the flags to R0, or reports an arithmetic interrupt instead. It replaces AWP's ad-hoc memory-read/register-select strobes with one explicit sequencer and handshake toward the CPU control and the memory bus.

---
 rtl/fpu_seq.sv | 215 +++++++++++++++++++++
 tb/tb_fpu_seq.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/fpu_seq.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : fpu_seq                                                       |
// | Purpose  : Operand/result sequencer in front of the AWP floating-point   |
// |            unit. Streams register and memory operands into AWP word by   |
// |            word, launches the operation, waits for completion, writes    |
// |            results back to r1..r3 and flags to R0, or reports an         |
// |            arithmetic interrupt / timeout alarm instead.                 |
// | Ports    : __clk/__rst   clock, synchronous active-high reset           |
// |            start/op/nrf/ea  request from CPU control                     |
// |            busy/ekc/irq/alarm  status back to CPU control                |
// |            reg_sel/reg_rdata/reg_we/reg_wdata  register file access      |
// |            mem_req/mem_addr/mem_ack/mem_data   memory read bus           |
// |            w/wld/efp/awp_done/zp/rsel/fi/zmvc  AWP operand/result side   |
// |            fl_we        write AWP zmvc flags into R0                     |
// | Revision : 1.0  initial release                                          |
// +--------------------------------------------------------------------------+
module fpu_seq #(
  parameter logic [7:0] MEM_TIMEOUT  = 8'd255,
  parameter logic [9:0] DONE_TIMEOUT = 10'd1023
) (
  input  logic        __clk,
  input  logic        __rst,
  input  logic        start,
  input  logic [7:9]  op,
  input  logic        nrf,
  input  logic [0:15] ea,
  output logic        busy,
  output logic [0:1]  reg_sel,
  input  logic [0:15] reg_rdata,
  output logic        reg_we,
  output logic [0:15] reg_wdata,
  output logic        mem_req,
  output logic [0:15] mem_addr,
  input  logic        mem_ack,
  input  logic [0:15] mem_data,
  output logic [0:15] w,
  output logic        wld,
  output logic        efp,
  input  logic        awp_done,
  input  logic [0:15] zp,
  output logic [0:1]  rsel,
  input  logic [0:3]  fi,
  input  logic [0:3]  zmvc,
  output logic        fl_we,
  output logic [0:3]  irq,
  output logic        alarm,
  output logic        ekc
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    RDREG = 3'd1,
    RDMEM = 3'd2,
    EXEC  = 3'd3,
    WB    = 3'd4,
    FIN   = 3'd5
  } state_t;

  state_t      state, state_nx;
  logic [7:9]  op_q;
  logic        nrf_q;
  logic [0:15] ea_q;
  logic [1:0]  k;        // word index within the current phase
  logic [9:0]  wcnt;     // wait counter for memory / AWP completion
  logic [0:3]  fi_q;
  logic        alarm_q;
  logic        wb_ok;    // writeback phase ran to completion

  logic        is_fp, is_mw, is_dw;
  logic [1:0]  reg_last, mem_last, res_last;
  logic        mem_to, done_to, exec_first;

  // zmvc goes straight from AWP into R0; this block only strobes fl_we.
  logic        unused_zmvc;
  assign unused_zmvc = ^zmvc;

  // NRF ignores op entirely, so the op decodes are masked by nrf_q.
  assign is_fp = !nrf_q && op_q[7];
  assign is_mw = !nrf_q && (op_q == 3'd2);
  assign is_dw = !nrf_q && (op_q == 3'd3);

  // Index of the last transfer in each phase (count - 1).
  assign reg_last = (nrf_q || is_fp) ? 2'd2 : (is_mw ? 2'd0 : 2'd1);
  assign mem_last = is_fp ? 2'd2 : ((is_mw || is_dw) ? 2'd0 : 2'd1);
  assign res_last = (nrf_q || is_fp) ? 2'd2 : 2'd1;

  // wcnt is 0 on the first RDMEM cycle of a word, so MEM_TIMEOUT request
  // cycles elapse before the abort. In EXEC, wcnt==0 marks the efp cycle and
  // the following cycles count the wait for awp_done.
  assign mem_to     = (wcnt == {2'b00, MEM_TIMEOUT - 8'd1});
  assign exec_first = (wcnt == 10'd0);
  assign done_to    = (wcnt == DONE_TIMEOUT);

  assign busy = (state != IDLE);

  always_comb begin
    state_nx  = state;
    reg_sel   = 2'd0;
    reg_we    = 1'b0;
    reg_wdata = 16'h0000;
    mem_req   = 1'b0;
    mem_addr  = 16'h0000;
    w         = 16'h0000;
    wld       = 1'b0;
    efp       = 1'b0;
    rsel      = 2'd0;
    fl_we     = 1'b0;
    irq       = 4'b0000;
    alarm     = 1'b0;
    ekc       = 1'b0;
    case (state)
      IDLE: begin
        if (start) state_nx = RDREG;
      end
      RDREG: begin
        // MW has a single register operand, r2.
        reg_sel = is_mw ? (k + 2'd2) : (k + 2'd1);
        w       = reg_rdata;
        wld     = 1'b1;
        if (k == reg_last) state_nx = nrf_q ? EXEC : RDMEM;
      end
      RDMEM: begin
        mem_req  = 1'b1;
        mem_addr = ea_q + {14'd0, k};
        if (mem_ack) begin
          w   = mem_data;
          wld = 1'b1;
          if (k == mem_last) state_nx = EXEC;
        end else if (mem_to) begin
          state_nx = FIN;
        end
      end
      EXEC: begin
        // awp_done coincident with efp is ignored; done wins over timeout.
        if (exec_first) begin
          efp = 1'b1;
        end else if (awp_done) begin
          state_nx = (fi != 4'b0000) ? FIN : WB;
        end else if (done_to) begin
          state_nx = FIN;
        end
      end
      WB: begin
        rsel      = k;
        reg_sel   = k + 2'd1;
        reg_wdata = zp;
        reg_we    = 1'b1;
        if (k == res_last) state_nx = FIN;
      end
      FIN: begin
        ekc      = 1'b1;
        fl_we    = wb_ok;
        irq      = fi_q;
        alarm    = alarm_q;
        state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge __clk) begin
    if (__rst) begin
      state   <= IDLE;
      op_q    <= 3'd0;
      nrf_q   <= 1'b0;
      ea_q    <= 16'h0000;
      k       <= 2'd0;
      wcnt    <= 10'd0;
      fi_q    <= 4'b0000;
      alarm_q <= 1'b0;
      wb_ok   <= 1'b0;
    end else begin
      state <= state_nx;
      case (state)
        IDLE: begin
          if (start) begin
            op_q    <= op;
            nrf_q   <= nrf;
            ea_q    <= ea;
            k       <= 2'd0;
            wcnt    <= 10'd0;
            fi_q    <= 4'b0000;
            alarm_q <= 1'b0;
            wb_ok   <= 1'b0;
          end
        end
        RDREG: k <= (k == reg_last) ? 2'd0 : k + 2'd1;
        RDMEM: begin
          if (mem_ack) begin
            k    <= (k == mem_last) ? 2'd0 : k + 2'd1;
            wcnt <= 10'd0;
          end else if (mem_to) begin
            alarm_q <= 1'b1;
          end else begin
            wcnt <= wcnt + 10'd1;
          end
        end
        EXEC: begin
          if (exec_first)    wcnt    <= 10'd1;
          else if (awp_done) fi_q    <= fi;
          else if (done_to)  alarm_q <= 1'b1;
          else               wcnt    <= wcnt + 10'd1;
        end
        WB: begin
          k <= k + 2'd1;
          if (k == res_last) wb_ok <= 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_fpu_seq.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : tb_fpu_seq                                                    |
// | Purpose  : Scoreboard bench for fpu_seq with register-file, memory and   |
// |            AWP models. Stimulus queues expected events; a forked         |
// |            monitor pops and compares them as the DUT produces them.      |
// | Revision : 1.0  initial release                                          |
// +--------------------------------------------------------------------------+
module tb_fpu_seq;

  localparam int K_MEM = 1;  // mem_req && mem_ack, data = mem_addr
  localparam int K_WLD = 2;  // wld, data = w
  localparam int K_EFP = 3;  // efp
  localparam int K_WE  = 4;  // reg_we, data = {reg_sel, reg_wdata}
  localparam int K_EKC = 5;  // ekc, data = {fl_we, irq, alarm}

  typedef struct {
    int          kind;
    logic [23:0] data;
  } ev_t;

  logic        clk, rst, start, nrf, busy, reg_we, mem_req, mem_ack;
  logic        wld, efp, awp_done, fl_we, alarm, ekc;
  logic [7:9]  op;
  logic [0:15] ea, reg_rdata, reg_wdata, mem_addr, mem_data, w, zp;
  logic [0:1]  reg_sel, rsel;
  logic [0:3]  fi, zmvc, irq;
  logic [63:0] outs;

  logic [15:0] regs [1:3];
  logic [15:0] zp_tab [0:3];
  logic [7:0]  mem_wait, mem_delay;
  logic        withhold;
  logic [3:0]  fi_val;

  ev_t exp_q[$];
  int  n_pass, n_total, memreq_cnt;

  fpu_seq #(.MEM_TIMEOUT(8'd4)) dut (
    .__clk(clk), .__rst(rst), .start(start), .op(op), .nrf(nrf), .ea(ea),
    .busy(busy), .reg_sel(reg_sel), .reg_rdata(reg_rdata), .reg_we(reg_we),
    .reg_wdata(reg_wdata), .mem_req(mem_req), .mem_addr(mem_addr),
    .mem_ack(mem_ack), .mem_data(mem_data), .w(w), .wld(wld), .efp(efp),
    .awp_done(awp_done), .zp(zp), .rsel(rsel), .fi(fi), .zmvc(zmvc),
    .fl_we(fl_we), .irq(irq), .alarm(alarm), .ekc(ekc)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  assign outs = {busy, reg_sel, reg_we, reg_wdata, mem_req, mem_addr, w, wld,
                 efp, rsel, fl_we, irq, alarm, ekc};

  function automatic logic [15:0] mem_val(input logic [15:0] a);
    if (a == 16'h0100) return 16'h0003;
    return a ^ 16'hA5A5;
  endfunction

  // Register file, memory and AWP models.
  always_comb reg_rdata = (reg_sel == 2'd0) ? 16'h0000 : regs[reg_sel];
  always_comb mem_data  = mem_val(mem_addr);
  always_comb mem_ack   = mem_req && !withhold && (mem_wait == mem_delay);
  always_comb zp        = zp_tab[rsel];
  always_comb fi        = fi_val;
  assign zmvc = 4'b1010;

  always @(posedge clk) begin
    if (rst || !mem_req || mem_ack) mem_wait <= 8'd0;
    else                            mem_wait <= mem_wait + 8'd1;
    awp_done <= !rst && efp;  // AWP completes one cycle after efp
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    n_total++;
    if (act === req) n_pass++;
    else $display("FAIL %s: actual %h required %h", name, act, req);
  endtask

  task automatic push(input int kind, input logic [23:0] data);
    ev_t e;
    e.kind = kind;
    e.data = data;
    exp_q.push_back(e);
  endtask

  task automatic push_we(input logic [1:0] sel, input logic [15:0] d);
    push(K_WE, {6'd0, sel, d});
  endtask

  task automatic push_ekc(input logic fl, input logic [3:0] ir, input logic al);
    push(K_EKC, {18'd0, fl, ir, al});
  endtask

  task automatic mon(input int kind, input logic [23:0] data);
    ev_t e;
    if (exp_q.size() == 0) begin
      n_total++;
      $display("FAIL unexpected_event: actual kind %0d data %h, required no event", kind, data);
    end else begin
      e = exp_q.pop_front();
      check($sformatf("event_kind%0d", e.kind), {8'(kind), data}, {8'(e.kind), e.data});
    end
  endtask

  task automatic monitor_loop();
    forever begin
      @(negedge clk);
      if (mem_req === 1'b1) memreq_cnt++;
      if (mem_req === 1'b1 && mem_ack === 1'b1) mon(K_MEM, {8'd0, mem_addr});
      if (wld === 1'b1)    mon(K_WLD, {8'd0, w});
      if (efp === 1'b1)    mon(K_EFP, 24'd0);
      if (reg_we === 1'b1) mon(K_WE, {6'd0, reg_sel, reg_wdata});
      if (ekc === 1'b1)    mon(K_EKC, {18'd0, fl_we, irq, alarm});
    end
  endtask

  // Issue one request, wait (bounded) for ekc and check latency and idle.
  task automatic run_op(input string name, input logic [2:0] o, input logic n,
                        input logic [15:0] a, input int exp_lat, input bit poke);
    int lat;
    bit seen;
    @(negedge clk);
    op = o; nrf = n; ea = a; start = 1'b1;
    lat = 0; seen = 1'b0;
    while (!seen && lat < 300) begin
      @(negedge clk);
      start = 1'b0;
      lat++;
      if (poke && lat == 3) start = 1'b1;  // must be ignored while busy
      if (ekc) seen = 1'b1;
    end
    start = 1'b0;
    check({name, "_ekc_seen"}, 64'(seen), 64'd1);
    if (seen) check({name, "_latency"}, 64'(lat), 64'(exp_lat));
    repeat (2) @(negedge clk);
    check({name, "_idle_outputs"}, outs, 64'd0);
    check({name, "_queue_empty"}, 64'(exp_q.size()), 64'd0);
  endtask

  initial begin
    int  mr0;
    bit  found;
    n_pass = 0; n_total = 0; memreq_cnt = 0;
    rst = 1'b1; start = 1'b0; op = 3'd0; nrf = 1'b0; ea = 16'h0000;
    withhold = 1'b0; mem_delay = 8'd0; fi_val = 4'b0000;
    for (int i = 1; i <= 3; i++) regs[i] = 16'h0000;
    for (int i = 0; i < 4; i++) zp_tab[i] = 16'h0000;
    fork
      monitor_loop();
    join_none
    repeat (3) @(negedge clk);
    check("reset_outputs", outs, 64'd0);
    rst = 1'b0;

    // MW: r2 then mem[0x0100], results to r1, r2; ekc 7 cycles after start.
    regs[2] = 16'h0005; zp_tab[0] = 16'h0000; zp_tab[1] = 16'h000F;
    push(K_WLD, 24'h000005); push(K_MEM, 24'h000100); push(K_WLD, 24'h000003);
    push(K_EFP, 24'd0); push_we(2'd1, 16'h0000); push_we(2'd2, 16'h000F);
    push_ekc(1'b1, 4'b0000, 1'b0);
    run_op("mw", 3'd2, 1'b0, 16'h0100, 7, 1'b0);

    // AF at 0xFFFE with two wait states per word: address wraps to 0x0000.
    regs[1] = 16'h1111; regs[2] = 16'h2222; regs[3] = 16'h3333;
    zp_tab[0] = 16'hAAAA; zp_tab[1] = 16'hBBBB; zp_tab[2] = 16'hCCCC;
    mem_delay = 8'd2;
    push(K_WLD, 24'h001111); push(K_WLD, 24'h002222); push(K_WLD, 24'h003333);
    push(K_MEM, 24'h00FFFE); push(K_WLD, 24'h005A5B);
    push(K_MEM, 24'h00FFFF); push(K_WLD, 24'h005A5A);
    push(K_MEM, 24'h000000); push(K_WLD, 24'h00A5A5);
    push(K_EFP, 24'd0);
    push_we(2'd1, 16'hAAAA); push_we(2'd2, 16'hBBBB); push_we(2'd3, 16'hCCCC);
    push_ekc(1'b1, 4'b0000, 1'b0);
    run_op("af", 3'd4, 1'b0, 16'hFFFE, 18, 1'b0);
    mem_delay = 8'd0;

    // DF with div/0 flag: no writeback, no fl_we, irq with ekc.
    regs[1] = 16'h0101; regs[2] = 16'h0202; regs[3] = 16'h0303;
    fi_val = 4'b0001;
    push(K_WLD, 24'h000101); push(K_WLD, 24'h000202); push(K_WLD, 24'h000303);
    push(K_MEM, 24'h000200); push(K_WLD, 24'h00A7A5);
    push(K_MEM, 24'h000201); push(K_WLD, 24'h00A7A4);
    push(K_MEM, 24'h000202); push(K_WLD, 24'h00A7A7);
    push(K_EFP, 24'd0);
    push_ekc(1'b0, 4'b0001, 1'b0);
    run_op("df", 3'd7, 1'b0, 16'h0200, 9, 1'b0);
    fi_val = 4'b0000;

    // NRF: three register reads, no memory traffic, three writebacks.
    regs[1] = 16'h0011; regs[2] = 16'h0022; regs[3] = 16'h0033;
    zp_tab[0] = 16'h1000; zp_tab[1] = 16'h2000; zp_tab[2] = 16'h3000;
    push(K_WLD, 24'h000011); push(K_WLD, 24'h000022); push(K_WLD, 24'h000033);
    push(K_EFP, 24'd0);
    push_we(2'd1, 16'h1000); push_we(2'd2, 16'h2000); push_we(2'd3, 16'h3000);
    push_ekc(1'b1, 4'b0000, 1'b0);
    mr0 = memreq_cnt;
    run_op("nrf", 3'd2, 1'b1, 16'h0100, 9, 1'b0);
    check("nrf_memreq_cycles", 64'(memreq_cnt - mr0), 64'd0);

    // MW with mem_ack withheld: 4 request cycles, then alarm with ekc.
    regs[2] = 16'h0777; withhold = 1'b1;
    push(K_WLD, 24'h000777);
    push_ekc(1'b0, 4'b0000, 1'b1);
    mr0 = memreq_cnt;
    run_op("timeout", 3'd2, 1'b0, 16'h0100, 6, 1'b1);
    check("timeout_memreq_cycles", 64'(memreq_cnt - mr0), 64'd4);
    withhold = 1'b0;

    // Reset during writeback after the first reg_we.
    regs[2] = 16'h0009; zp_tab[0] = 16'h0123; zp_tab[1] = 16'h0456;
    push(K_WLD, 24'h000009); push(K_MEM, 24'h000100); push(K_WLD, 24'h000003);
    push(K_EFP, 24'd0); push_we(2'd1, 16'h0123);
    @(negedge clk);
    op = 3'd2; nrf = 1'b0; ea = 16'h0100; start = 1'b1;
    found = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      @(negedge clk);
      start = 1'b0;
      if (reg_we) found = 1'b1;
    end
    check("reset_reach_wb", 64'(found), 64'd1);
    rst = 1'b1;
    @(negedge clk);
    check("reset_mid_outputs", outs, 64'd0);
    rst = 1'b0;
    repeat (4) @(negedge clk);
    check("reset_mid_queue", 64'(exp_q.size()), 64'd0);

    // Fresh MW after the abort runs normally.
    regs[2] = 16'h0005; zp_tab[0] = 16'h0000; zp_tab[1] = 16'h000F;
    push(K_WLD, 24'h000005); push(K_MEM, 24'h000100); push(K_WLD, 24'h000003);
    push(K_EFP, 24'd0); push_we(2'd1, 16'h0000); push_we(2'd2, 16'h000F);
    push_ekc(1'b1, 4'b0000, 1'b0);
    run_op("mw_after_reset", 3'd2, 1'b0, 16'h0100, 7, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
`default_nettype wire
